// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } ch_state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divisors below MIN_DIV cannot produce a period, so they are raised to it.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Divisor load handshake between a controller (master) and the divider (slave).
interface multi_clock_divider_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 load_valid;
  logic [2:0]           load_ch;
  logic [CNT_WIDTH-1:0] load_div;
  logic                 load_ready;

  modport master (output load_valid, load_ch, load_div, input load_ready);
  modport slave  (input load_valid, load_ch, load_div, output load_ready);
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, divisor, shadow divisor and run/stop FSM.
// Optional CLK_DIV_TICK_EN adds a one-cycle tick on each rising clk_out.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_div,
  output logic                 clk_out,
  output logic                 running,
  output logic                 pending
`ifdef CLK_DIV_TICK_EN
  , output logic               tick
`endif
);

  ch_state_t            state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, div, div_n, shadow, shadow_n;
  logic                 pend, pend_n;
  logic                 wrap, out_n;
`ifdef CLK_DIV_TICK_EN
  logic                 tick_n;
`endif

  assign wrap    = (cnt == div - 1'b1);
  assign pending = pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div     <= CNT_WIDTH'(DEFAULT_DIV);
      shadow  <= CNT_WIDTH'(DEFAULT_DIV);
      pend    <= 1'b0;
      clk_out <= 1'b0;
`ifdef CLK_DIV_TICK_EN
      tick    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div     <= div_n;
      shadow  <= shadow_n;
      pend    <= pend_n;
      clk_out <= out_n;
`ifdef CLK_DIV_TICK_EN
      tick    <= tick_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = wrap ? '0 : cnt + 1'b1;
    div_n    = div;
    shadow_n = shadow;
    pend_n   = pend;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (load) div_n = load_div;
        if (en)   state_n = RUN;
      end
      RUN: begin
        if (load) begin
          shadow_n = load_div;
          pend_n   = 1'b1;
        end
        if (!en)         state_n = STOP;
        else if (pend_n) state_n = PEND;
      end
      PEND: begin
        if (wrap) begin
          div_n   = shadow;
          pend_n  = 1'b0;
          state_n = en ? RUN : STOP;
        end else if (!en) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (wrap && pend) begin
          div_n  = shadow;
          pend_n = 1'b0;
        end
        // A load landing on the wrap into IDLE has no later boundary to wait for.
        if (load) begin
          if (wrap && !en) begin
            div_n = load_div;
          end else begin
            shadow_n = load_div;
            pend_n   = 1'b1;
          end
        end
        if (en)        state_n = pend_n ? PEND : RUN;
        else if (wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN) || (state == PEND);
    out_n   = (state != IDLE) && (cnt < (div >> 1));
`ifdef CLK_DIV_TICK_EN
    tick_n  = out_n && !clk_out;
`endif
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers with a shared load port.
// Optional CLK_DIV_TICK_EN adds the per-channel tick output.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  multi_clock_divider_if.slave load,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] running
`ifdef CLK_DIV_TICK_EN
  , output logic [NUM_CH-1:0] tick
`endif
);

  logic [NUM_CH-1:0]    pending, ch_load;
  logic [7:0]           pend_pad;
  logic                 in_range, accept;
  logic [CNT_WIDTH-1:0] div_clamped;

  // Pad to the full 3-bit channel space so any load_ch indexes safely.
  always_comb begin
    pend_pad              = '0;
    pend_pad[NUM_CH-1:0]  = pending;
  end

  assign in_range        = ({29'd0, load.load_ch} < NUM_CH);
  assign load.load_ready = in_range && !pend_pad[load.load_ch];
  assign accept          = load.load_valid && load.load_ready;
  assign div_clamped     = CNT_WIDTH'(clamp_div(32'(load.load_div)));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_load[i] = accept && (load.load_ch == 3'(i));

    clk_div_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clock_in),
      .rst      (reset),
      .en       (ch_en[i]),
      .load     (ch_load[i]),
      .load_div (div_clamped),
      .clk_out  (clock_out[i]),
      .running  (running[i]),
      .pending  (pending[i])
`ifdef CLK_DIV_TICK_EN
      , .tick   (tick[i])
`endif
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed and randomized checks of multi_clock_divider against a period-level model.
module tb_multi_clock_divider;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_WIDTH   = 16;
  localparam int unsigned DEFAULT_DIV = 10;

  logic              clock_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] running;
`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  multi_clock_divider_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  multi_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_WIDTH   (CNT_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .ch_en     (ch_en),
    .load      (bus),
    .clock_out (clock_out),
    .running   (running)
`ifdef CLK_DIV_TICK_EN
    , .tick    (tick)
`endif
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;

  // Model: a channel is "counting" while a period is in progress, "run" when ch_en was high.
  int unsigned       m_cnt    [NUM_CH];
  int unsigned       m_div    [NUM_CH];
  int unsigned       m_shadow [NUM_CH];
  bit                m_pend   [NUM_CH];
  bit                m_count  [NUM_CH];
  bit                m_run    [NUM_CH];
  logic [NUM_CH-1:0] e_out, e_run, e_tick;

  function automatic void model_reset();
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_div[c] = DEFAULT_DIV; m_shadow[c] = DEFAULT_DIV;
      m_pend[c] = 1'b0; m_count[c] = 1'b0; m_run[c] = 1'b0;
    end
    e_out = '0; e_run = '0; e_tick = '0;
  endfunction

  function automatic bit model_ready(int unsigned ch);
    if (ch >= NUM_CH) return 1'b0;
    return !m_pend[ch];
  endfunction

  function automatic void model_step(logic [NUM_CH-1:0] en, bit lv, int unsigned lch, int unsigned ldiv);
    bit acc;
    acc = lv && model_ready(lch);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bit wrap, stopping, nxt_count, out;
      int unsigned nd;
      wrap      = m_count[c] && (m_cnt[c] == m_div[c] - 1);
      stopping  = m_count[c] && !m_run[c];
      out       = m_count[c] && (m_cnt[c] < m_div[c] / 2);
      e_tick[c] = out && !e_out[c];
      e_out[c]  = out;
      nxt_count = en[c] || (m_count[c] && !(stopping && wrap));
      m_cnt[c]  = (m_count[c] && !wrap) ? m_cnt[c] + 1 : 0;
      if (wrap && m_pend[c]) begin
        m_div[c]  = m_shadow[c];
        m_pend[c] = 1'b0;
      end
      if (acc && lch == c) begin
        nd = (ldiv < 2) ? 2 : ldiv;
        if (!m_count[c] || !nxt_count) m_div[c] = nd;
        else begin
          m_shadow[c] = nd;
          m_pend[c]   = 1'b1;
        end
      end
      m_count[c] = nxt_count;
      m_run[c]   = en[c];
      e_run[c]   = en[c];
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    #1;
    chk("load_ready", {31'd0, bus.load_ready}, {31'd0, model_ready({29'd0, bus.load_ch})});
    @(posedge clock_in);
    model_step(ch_en, bus.load_valid, {29'd0, bus.load_ch}, {16'd0, bus.load_div});
    #1;
    chk("clock_out", 32'(clock_out), 32'(e_out));
    chk("running", 32'(running), 32'(e_run));
`ifdef CLK_DIV_TICK_EN
    chk("tick", 32'(tick), 32'(e_tick));
`endif
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic load1(logic [2:0] ch, logic [CNT_WIDTH-1:0] d);
    bus.load_valid = 1'b1;
    bus.load_ch    = ch;
    bus.load_div   = d;
    cycle();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_cnt(int unsigned ch, int unsigned val);
    int k = 0;
    while (!(m_count[ch] && m_run[ch] && m_cnt[ch] == val) && k < 64) begin
      cycle();
      k++;
    end
    chk("wait_cnt_timeout", {31'd0, (k < 64)}, 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    ch_en          = '0;
    bus.load_valid = 1'b0;
    bus.load_ch    = 3'd0;
    bus.load_div   = '0;
    model_reset();
    repeat (2) @(posedge clock_in);
    #1;
    chk("reset_clock_out", 32'(clock_out), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_load_ready", {31'd0, bus.load_ready}, 32'd1);
    reset = 1'b0;

    // Channel 0 at the default divisor.
    ch_en = 4'b0001;
    run(25);

    // Channel 1 programmed while idle, then enabled.
    load1(3'd1, 16'd7);
    ch_en = 4'b0011;
    run(20);

    // Channel 0 reprogrammed mid-period at cnt=3; ready stays low until the swap.
    wait_cnt(0, 3);
    load1(3'd0, 16'd4);
    bus.load_ch = 3'd0;
    run(16);

    // Channel 2 stopped mid-high.
    load1(3'd2, 16'd8);
    ch_en = 4'b0111;
    wait_cnt(2, 2);
    ch_en = 4'b0011;
    run(12);

    // Degenerate divisors clamp to 2; out-of-range channel is refused.
    load1(3'd3, 16'd1);
    load1(3'd2, 16'd0);
    ch_en = 4'b1111;
    run(8);
    bus.load_valid = 1'b1;
    bus.load_ch    = 3'd5;
    bus.load_div   = 16'd3;
    #1;
    chk("ready_out_of_range", {31'd0, bus.load_ready}, 32'd0);
    cycle();
    bus.load_valid = 1'b0;
    run(6);

    // Randomized enables and loads.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        logic [1:0] k;
        k = 2'($urandom_range(0, NUM_CH - 1));
        ch_en[k] = ~ch_en[k];
      end
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.load_ch    = 3'($urandom_range(0, 5));
      bus.load_div   = CNT_WIDTH'($urandom_range(0, 9));
      cycle();
    end
    bus.load_valid = 1'b0;

    // Asynchronous reset mid-period.
    ch_en = '1;
    run(7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clock_out", 32'(clock_out), 32'd0);
    chk("async_running", 32'(running), 32'd0);
    model_reset();
    ch_en = '0;
    @(posedge clock_in);
    #1;
    chk("held_clock_out", 32'(clock_out), 32'd0);
    #2;
    reset = 1'b0;
    ch_en = 4'b0001;
    bus.load_ch = 3'd0;
    run(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
